// File: rtl/tl_pkg.sv
// Shared types for the transmit-lane arbiter: stream beat format and arbiter state.
package tl_pkg;

   localparam int unsigned TL_DATA_W = 16;

   // One beat of a packet stream; sop/eop frame the packet.
   typedef struct packed {
      logic                 sop;
      logic                 eop;
      logic [TL_DATA_W-1:0] data;
   } tl_stream_t;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } tl_arb_state_e;

   // A packet must open with sop in IDLE and must not re-open while locked.
   function automatic logic is_framing_err(input tl_arb_state_e st, input tl_stream_t beat);
      if (st == ARB_IDLE) begin
         is_framing_err = ~beat.sop;
      end else begin
         is_framing_err = beat.sop;
      end
   endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Round-robin search: first asserted valid at or above ptr_i, wrapping to 0.
module tl_rr_pick #(
   parameter int N_REQ   = 3,
   parameter int GRANT_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0]   valid_i,
   input  logic [GRANT_W-1:0] ptr_i,
   output logic [GRANT_W-1:0] idx_o,
   output logic               found_o
);

   localparam int SUM_W = GRANT_W + 1;

   // Walk candidates ptr, ptr+1, ... modulo N_REQ and keep the first valid one.
   always_comb begin
      logic [SUM_W-1:0]   sum_v;
      logic [GRANT_W-1:0] cand_v;
      idx_o   = '0;
      found_o = 1'b0;
      sum_v   = '0;
      cand_v  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum_v = {1'b0, ptr_i} + SUM_W'(k);
         if (sum_v >= SUM_W'(N_REQ)) begin
            sum_v = sum_v - SUM_W'(N_REQ);
         end else begin
         end
         cand_v = sum_v[GRANT_W-1:0];
         if (!found_o && valid_i[cand_v]) begin
            found_o = 1'b1;
            idx_o   = cand_v;
         end else begin
         end
      end
   end

endmodule

// File: rtl/tl_tx_arbiter.sv
// Packet-level round-robin arbiter: merges N_REQ beat streams into one,
// holding the grant for the whole packet, through a one-entry output register.
module tl_tx_arbiter
   import tl_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int GRANT_W = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  tl_stream_t         req_data_i [N_REQ],
   input  logic [N_REQ-1:0]   req_valid_i,
   output logic [N_REQ-1:0]   req_ready_o,
   output tl_stream_t         out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               busy_o,
   output logic [GRANT_W-1:0] grant_o,
   output logic               err_o
);

   tl_arb_state_e      state_q, state_d;
   logic [GRANT_W-1:0] grant_q, grant_d;
   logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
   tl_stream_t         out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               err_q, err_d;

   logic               slot_free_s;
   logic               found_s;
   logic               accept_s;
   logic [GRANT_W-1:0] pick_idx_s;
   logic [GRANT_W-1:0] sel_idx_s;
   logic [N_REQ-1:0]   ready_s;
   tl_stream_t         sel_beat_s;

   function automatic logic [GRANT_W-1:0] next_idx(input logic [GRANT_W-1:0] idx);
      if (idx == GRANT_W'(N_REQ - 1)) begin
         next_idx = '0;
      end else begin
         next_idx = idx + GRANT_W'(1);
      end
   endfunction

   tl_rr_pick #(
      .N_REQ   (N_REQ),
      .GRANT_W (GRANT_W)
   ) u_rr_pick (
      .valid_i (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx_s),
      .found_o (found_s)
   );

   // The output register can take a beat when empty or draining this cycle.
   assign slot_free_s = !out_valid_q || out_ready_i;
   assign sel_beat_s  = req_data_i[sel_idx_s];

   // Choose the source for this cycle and raise exactly its ready; never looks at beat data.
   always_comb begin
      ready_s   = '0;
      sel_idx_s = grant_q;
      accept_s  = 1'b0;
      if (slot_free_s) begin
         if (state_q == ARB_LOCKED) begin
            ready_s[grant_q] = 1'b1;
            sel_idx_s        = grant_q;
            accept_s         = req_valid_i[grant_q];
         end else if (found_s) begin
            ready_s[pick_idx_s] = 1'b1;
            sel_idx_s           = pick_idx_s;
            accept_s            = 1'b1;
         end else begin
         end
      end else begin
      end
   end

   // Next-state: load accepted beat, track packet lock and round-robin pointer.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      err_d       = 1'b0;
      if (accept_s) begin
         out_data_d  = sel_beat_s;
         out_valid_d = 1'b1;
         err_d       = is_framing_err(state_q, sel_beat_s);
         case (state_q)
            ARB_IDLE: begin
               grant_d = sel_idx_s;
               if (sel_beat_s.eop) begin
                  rr_ptr_d = next_idx(sel_idx_s);
               end else begin
                  state_d = ARB_LOCKED;
               end
            end
            ARB_LOCKED: begin
               if (sel_beat_s.eop) begin
                  state_d  = ARB_IDLE;
                  rr_ptr_d = next_idx(grant_q);
               end else begin
               end
            end
            default: begin
               state_d = ARB_IDLE;
            end
         endcase
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end else begin
      end
   end

   // State and output registers; reset abandons any partial packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   assign req_ready_o = ready_s;
   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign busy_o      = (state_q == ARB_LOCKED);
   assign grant_o     = grant_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Self-checking bench for tl_tx_arbiter: directed scenarios plus a randomized
// run against a packet-level reference model.
module tb_tl_tx_arbiter;
   import tl_pkg::*;

   localparam int N  = 3;
   localparam int GW = $clog2(N);

   logic           clk;
   logic           rst_n;
   tl_stream_t     req_data [N];
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready_o;
   tl_stream_t     out_data_o;
   logic           out_valid_o;
   logic           out_ready;
   logic           busy_o;
   logic [GW-1:0]  grant_o;
   logic           err_o;

   int n_tests;
   int n_fail;

   // sources
   int  s_left  [N];
   int  s_seq   [N];
   int  s_len   [N];
   bit  s_fsop  [N];
   bit  s_cont  [N];
   bit  rnd_mode;
   logic [N-1:0] acc_vec;

   // reference model
   bit         m_locked;
   int         m_owner;
   int         m_rr;
   int         m_grant;
   logic       m_out_valid;
   logic       m_err;
   tl_stream_t m_out_data;

   tl_stream_t obs_q [$];
   int         err_cnt;

   tl_tx_arbiter #(.N_REQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_data_i  (req_data),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready),
      .busy_o      (busy_o),
      .grant_o     (grant_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic tl_stream_t mk_beat(input int id, input int seq, input bit sop, input bit eop);
      tl_stream_t b;
      b.sop  = sop;
      b.eop  = eop;
      b.data = {4'(id), 12'(seq)};
      return b;
   endfunction

   task automatic new_packet(input int i);
      s_left[i]   = rnd_mode ? int'($urandom_range(1, 4)) : s_len[i];
      req_data[i] = mk_beat(i, s_seq[i],
                            rnd_mode ? ($urandom_range(0, 15) != 0) : s_fsop[i],
                            s_left[i] == 1);
   endtask

   task automatic start_src(input int i, input int len, input bit fsop, input bit cont);
      s_len[i]     = len;
      s_fsop[i]    = fsop;
      s_cont[i]    = cont;
      new_packet(i);
      req_valid[i] = 1'b1;
   endtask

   // Advance every source according to what was accepted last cycle.
   task automatic src_update();
      for (int i = 0; i < N; i++) begin
         if (acc_vec[i]) begin
            s_left[i]--;
            s_seq[i]++;
            if (s_left[i] == 0) begin
               if (rnd_mode || s_cont[i]) begin
                  new_packet(i);
                  req_valid[i] = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
               end else begin
                  req_valid[i] = 1'b0;
               end
            end else begin
               req_data[i] = mk_beat(i, s_seq[i],
                                     rnd_mode ? ($urandom_range(0, 15) == 0) : 1'b0,
                                     s_left[i] == 1);
               req_valid[i] = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
         end else if (rnd_mode && !req_valid[i]) begin
            req_valid[i] = ($urandom_range(0, 2) == 0);
         end
      end
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // One clock: compare DUT against the model at negedge, then advance the model.
   task automatic run_cycle();
      logic [N-1:0] exp_ready;
      bit           slot;
      int           win;
      int           idx;
      tl_stream_t   d;
      @(negedge clk);
      slot      = !m_out_valid || out_ready;
      exp_ready = '0;
      win       = -1;
      if (slot) begin
         if (m_locked) begin
            win = m_owner;
         end else begin
            for (int k = 0; k < N; k++) begin
               idx = (m_rr + k) % N;
               if (win < 0 && req_valid[idx]) win = idx;
            end
         end
         if (win >= 0) exp_ready[win] = 1'b1;
      end
      n_tests += 6;
      if (req_ready_o !== exp_ready) begin
         n_fail++; $display("FAIL req_ready @%0t: got %b expected %b", $time, req_ready_o, exp_ready);
      end
      if (out_valid_o !== m_out_valid) begin
         n_fail++; $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid_o, m_out_valid);
      end
      if (out_data_o !== m_out_data) begin
         n_fail++; $display("FAIL out_data @%0t: got %h expected %h", $time, out_data_o, m_out_data);
      end
      if (busy_o !== m_locked) begin
         n_fail++; $display("FAIL busy @%0t: got %b expected %b", $time, busy_o, m_locked);
      end
      if (grant_o !== GW'(m_grant)) begin
         n_fail++; $display("FAIL grant @%0t: got %0d expected %0d", $time, grant_o, m_grant);
      end
      if (err_o !== m_err) begin
         n_fail++; $display("FAIL err @%0t: got %b expected %b", $time, err_o, m_err);
      end
      if (out_valid_o === 1'b1 && out_ready) obs_q.push_back(out_data_o);
      if (err_o === 1'b1) err_cnt++;
      acc_vec = req_valid & exp_ready;
      if (acc_vec != '0) begin
         d           = req_data[win];
         m_out_data  = d;
         m_out_valid = 1'b1;
         m_err       = m_locked ? d.sop : !d.sop;
         if (!m_locked) begin
            m_grant = win;
            if (d.eop) m_rr = (win + 1) % N;
            else begin m_locked = 1'b1; m_owner = win; end
         end else if (d.eop) begin
            m_locked = 1'b0;
            m_rr     = (m_owner + 1) % N;
         end
      end else begin
         m_err = 1'b0;
         if (out_ready) m_out_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_n(input int n);
      for (int c = 0; c < n; c++) begin
         run_cycle();
         src_update();
      end
   endtask

   // Apply reset, clear bench state and check the reset values.
   task automatic reset_dut();
      rst_n     = 1'b0;
      rnd_mode  = 1'b0;
      out_ready = 1'b1;
      req_valid = '0;
      acc_vec   = '0;
      for (int i = 0; i < N; i++) begin
         req_data[i] = '0; s_left[i] = 0; s_seq[i] = 0;
         s_len[i] = 1; s_fsop[i] = 1'b1; s_cont[i] = 1'b0;
      end
      m_locked = 1'b0; m_owner = 0; m_rr = 0; m_grant = 0;
      m_out_valid = 1'b0; m_err = 1'b0; m_out_data = '0;
      obs_q.delete();
      err_cnt = 0;
      @(posedge clk);
      #1;
      n_tests += 6;
      if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid_o); end
      if (out_data_o !== '0)    begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", out_data_o); end
      if (busy_o !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
      if (grant_o !== '0)       begin n_fail++; $display("FAIL rst_grant: got %0d expected 0", grant_o); end
      if (err_o !== 1'b0)       begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_o); end
      if (req_ready_o !== '0)   begin n_fail++; $display("FAIL rst_ready: got %b expected 0", req_ready_o); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_dut();
      run_n(2);
   endtask

   task automatic test_round_robin();
      int exp_ids [6] = '{0, 1, 2, 0, 1, 2};
      reset_dut();
      for (int i = 0; i < N; i++) start_src(i, 1, 1'b1, 1'b1);
      run_n(8);
      n_tests++;
      if (obs_q.size() != 7) begin n_fail++; $display("FAIL rr_count: got %0d expected 7", obs_q.size()); end
      for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
         n_tests++;
         if (int'(obs_q[k].data[15:12]) != exp_ids[k]) begin
            n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, obs_q[k].data[15:12], exp_ids[k]);
         end
      end
   endtask

   task automatic test_lock();
      int exp_ids [7] = '{1, 1, 1, 1, 0, 0, 0};
      reset_dut();
      start_src(1, 4, 1'b1, 1'b0);
      run_n(1);
      start_src(0, 1, 1'b1, 1'b1);
      run_n(7);
      n_tests++;
      if (obs_q.size() != 7) begin n_fail++; $display("FAIL lock_count: got %0d expected 7", obs_q.size()); end
      for (int k = 0; k < 7 && k < obs_q.size(); k++) begin
         n_tests++;
         if (int'(obs_q[k].data[15:12]) != exp_ids[k]) begin
            n_fail++; $display("FAIL lock_order[%0d]: got %0d expected %0d", k, obs_q[k].data[15:12], exp_ids[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      tl_stream_t held;
      reset_dut();
      start_src(0, 4, 1'b1, 1'b0);
      start_src(1, 1, 1'b1, 1'b1);
      run_n(2);
      out_ready = 1'b0;
      held = mk_beat(0, 1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests += 3;
         if (req_ready_o !== '0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, req_ready_o); end
         if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid_o); end
         if (out_data_o !== held) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected %h", c, out_data_o, held); end
         run_cycle();
         src_update();
      end
      out_ready = 1'b1;
      run_n(6);
      n_tests++;
      if (obs_q.size() < 5) begin
         n_fail++; $display("FAIL bp_count: got %0d expected at least 5", obs_q.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs_q[k].data !== {4'd0, 12'(k)}) begin
               n_fail++; $display("FAIL bp_seq[%0d]: got %h expected %h", k, obs_q[k].data, {4'd0, 12'(k)});
            end
         end
         n_tests++;
         if (obs_q[4].data[15:12] !== 4'd1) begin
            n_fail++; $display("FAIL bp_next: got %0d expected 1", obs_q[4].data[15:12]);
         end
      end
   endtask

   task automatic test_sop_error();
      tl_stream_t eb;
      reset_dut();
      start_src(2, 3, 1'b0, 1'b0);
      run_n(6);
      n_tests += 2;
      if (err_cnt != 1) begin n_fail++; $display("FAIL sop_err_count: got %0d expected 1", err_cnt); end
      if (obs_q.size() != 3) begin n_fail++; $display("FAIL sop_beats: got %0d expected 3", obs_q.size()); end
      for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
         eb = mk_beat(2, k, 1'b0, k == 2);
         n_tests++;
         if (obs_q[k] !== eb) begin n_fail++; $display("FAIL sop_beat[%0d]: got %h expected %h", k, obs_q[k], eb); end
      end
   endtask

   task automatic test_reset_mid_packet();
      reset_dut();
      start_src(1, 5, 1'b1, 1'b0);
      run_n(2);
      rst_n = 1'b0;
      #1;
      n_tests += 2;
      if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid_o); end
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
      reset_dut();
      for (int i = 0; i < N; i++) start_src(i, 1, 1'b1, 1'b1);
      run_n(3);
      n_tests++;
      if (obs_q.size() < 1) begin
         n_fail++; $display("FAIL midrst_first: got no beat expected requester 0");
      end else if (obs_q[0].data[15:12] !== 4'd0) begin
         n_fail++; $display("FAIL midrst_first: got %0d expected 0", obs_q[0].data[15:12]);
      end
   endtask

   task automatic test_wrap();
      int exp_ids [3] = '{2, 1, 2};
      reset_dut();
      start_src(2, 1, 1'b1, 1'b0);
      run_n(1);
      n_tests++;
      if (grant_o !== GW'(2)) begin n_fail++; $display("FAIL wrap_grant: got %0d expected 2", grant_o); end
      start_src(1, 1, 1'b1, 1'b0);
      start_src(2, 1, 1'b1, 1'b0);
      run_n(4);
      n_tests++;
      if (obs_q.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", obs_q.size()); end
      for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
         n_tests++;
         if (int'(obs_q[k].data[15:12]) != exp_ids[k]) begin
            n_fail++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", k, obs_q[k].data[15:12], exp_ids[k]);
         end
      end
   endtask

   task automatic test_random();
      reset_dut();
      rnd_mode = 1'b1;
      for (int i = 0; i < N; i++) begin
         new_packet(i);
         req_valid[i] = ($urandom_range(0, 1) == 1);
      end
      run_n(2000);
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL rnd_traffic: got 0 beats expected some"); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      test_reset();
      test_round_robin();
      test_lock();
      test_backpressure();
      test_sop_error();
      test_reset_mid_packet();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
